// File: rtl/exec_monitor_pkg.sv
// Shared types and constants for the execution monitor.
// Trace entries are packed as {pc, wa, wd, we}.
package exec_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int unsigned NOP_INSTR = 0;

    function automatic int entry_width(input int n, input int m);
        return 2 * n + m + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO with occupancy count.
// Head data reads back as zero while empty.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/exec_monitor.sv
// Execution monitor: retired-instruction trace, cycle/instr counters
// and sticky halt after a run of consecutive no-ops.
module exec_monitor
    import exec_monitor_pkg::*;
#(
    parameter int N         = 16,
    parameter int M         = 4,
    parameter int DEPTH     = 16,
    parameter int HALT_NOPS = 1,
    parameter int CW        = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [N-1:0]             pc,
    input  logic [N-1:0]             instr,
    input  logic                     rf_we,
    input  logic [M-1:0]             rf_wa,
    input  logic [N-1:0]             rf_wd,
    input  logic                     trace_rd,
    output logic                     trace_valid,
    output logic [N-1:0]             trace_pc,
    output logic [M-1:0]             trace_wa,
    output logic [N-1:0]             trace_wd,
    output logic                     trace_we,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic                     halted,
    output logic [1:0]               state,
    output logic [CW-1:0]            cycle_count,
    output logic [CW-1:0]            instr_count
);

    typedef struct packed {
        logic [N-1:0] pc;
        logic [M-1:0] wa;
        logic [N-1:0] wd;
        logic         we;
    } trace_entry_t;

    localparam int NW = $clog2(HALT_NOPS + 1);
    localparam int EW = entry_width(N, M);

    state_t        st_q;
    state_t        st_d;
    logic [NW-1:0] nop_q;
    logic          active;
    logic          is_nop;
    logic          nop_hit;
    logic          push_req;
    logic          pop_eff;
    logic          fifo_full;
    logic          fifo_empty;
    trace_entry_t  wr_e;
    trace_entry_t  rd_e;
    logic [EW-1:0] rd_bits;

    assign is_nop   = (instr == N'(NOP_INSTR));
    assign active   = enable & (st_q != HALTED);
    assign nop_hit  = is_nop && ((int'(nop_q) + 1) >= HALT_NOPS);
    assign push_req = active & ~is_nop & (~mode | rf_we);
    assign pop_eff  = trace_rd & ~fifo_empty;

    assign wr_e = '{pc: pc, wa: rf_wa, wd: rf_wd, we: rf_we};
    assign rd_e = trace_entry_t'(rd_bits);

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE:    if (enable) st_d = nop_hit ? HALTED : RUN;
            RUN:     if (enable && nop_hit) st_d = HALTED;
            HALTED:  st_d = HALTED;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q   <= IDLE;
            halted <= 1'b0;
        end else begin
            st_q   <= st_d;
            halted <= (st_d == HALTED);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nop_q       <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else if (active) begin
            nop_q <= is_nop ? nop_q + 1'b1 : '0;
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (!is_nop && instr_count != '1) instr_count <= instr_count + 1'b1;
        end
    end

    // Drop only when full and no pop frees a slot this cycle.
    always_ff @(posedge clk) begin
        if (!reset)                             overflow <= 1'b0;
        else if (push_req & fifo_full & ~pop_eff) overflow <= 1'b1;
    end

    trace_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (trace_rd),
        .wdata (wr_e),
        .rdata (rd_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (trace_count)
    );

    assign trace_valid = ~fifo_empty;
    assign trace_pc    = rd_e.pc;
    assign trace_wa    = rd_e.wa;
    assign trace_wd    = rd_e.wd;
    assign trace_we    = rd_e.we;
    assign state       = st_q;

endmodule
